// File: rtl/pll_lock_mgr.sv
// PLL lock manager: pulses the PLL reset, waits for a lock that holds long enough,
// then releases the downstream system reset. Retries on timeout or lock loss.
module pll_lock_mgr #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_fail,
  output logic [7:0] loss_cnt,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int RW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  function automatic logic [7:0] sat_inc_loss(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [RW-1:0] sat_inc_retry(input logic [RW-1:0] v);
    return (v == RW'(MAX_RETRIES)) ? v : v + RW'(1);
  endfunction

  logic          r_sync1;
  logic          r_locked_s;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry_cnt;
  logic          r_pll_rst;
  logic          r_sys_rst_n;
  logic          r_pll_fail;
  logic [7:0]    r_loss_cnt;

  logic          w_rst_done;
  logic          w_lock_to;
  logic          w_stable_done;
  logic [RW-1:0] w_retry_nxt;

  // Timer holds (cycles spent in state - 1) on the last cycle of each window.
  assign w_rst_done    = (r_timer == TW'(RST_CYCLES - 1));
  assign w_lock_to     = (r_timer == TW'(LOCK_TIMEOUT - 1));
  assign w_stable_done = (r_timer == TW'(STABLE_CYCLES - 1));
  assign w_retry_nxt   = sat_inc_retry(r_retry_cnt);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_locked_s  <= 1'b0;
      r_state     <= S_RESET_PLL;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_pll_fail  <= 1'b0;
      r_loss_cnt  <= 8'd0;
    end else begin
      r_sync1    <= locked;
      r_locked_s <= r_sync1;
      r_timer    <= r_timer + TW'(1);
      case (r_state)
        S_RESET_PLL: begin
          if (w_rst_done) begin
            r_state   <= S_WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_timer   <= '0;
          end
        end
        S_WAIT_LOCK: begin
          // A lock seen on the timeout cycle takes priority over the retry.
          if (r_locked_s) begin
            r_state <= S_STABLE;
            r_timer <= '0;
          end else if (w_lock_to) begin
            r_state     <= S_RESET_PLL;
            r_pll_rst   <= 1'b1;
            r_timer     <= '0;
            r_retry_cnt <= w_retry_nxt;
            if (w_retry_nxt == RW'(MAX_RETRIES)) r_pll_fail <= 1'b1;
          end
        end
        S_STABLE: begin
          if (!r_locked_s) begin
            r_state     <= S_RESET_PLL;
            r_pll_rst   <= 1'b1;
            r_timer     <= '0;
            r_retry_cnt <= w_retry_nxt;
            if (w_retry_nxt == RW'(MAX_RETRIES)) r_pll_fail <= 1'b1;
          end else if (w_stable_done) begin
            r_state     <= S_RUN;
            r_sys_rst_n <= 1'b1;
            r_timer     <= '0;
            r_retry_cnt <= '0;
          end
        end
        S_RUN: begin
          if (!r_locked_s) begin
            r_state     <= S_RESET_PLL;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_timer     <= '0;
            r_loss_cnt  <= sat_inc_loss(r_loss_cnt);
          end
        end
      endcase
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign pll_fail  = r_pll_fail;
  assign loss_cnt  = r_loss_cnt;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Bench for pll_lock_mgr: directed scenarios plus random lock patterns, each cycle
// compared against a cycle-count reference model of the lock sequencing rules.
module tb_pll_lock_mgr;
  localparam int RST = 4;
  localparam int TO  = 20;
  localparam int ST  = 8;
  localparam int MR  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_fail;
  logic [7:0] loss_cnt;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  pll_lock_mgr #(
    .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST), .MAX_RETRIES(MR)
  ) u_dut (
    .refclk(clk), .rst_n(rst_n), .locked(locked), .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n), .pll_fail(pll_fail), .loss_cnt(loss_cnt), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase (0 reset pulse, 1 waiting, 2 proving, 3 running),
  // cycles completed in phase, attempt counter, sticky fail, loss counter.
  int m_state = 0;
  int m_in = 0;
  int m_retries = 0;
  int m_loss = 0;
  bit m_fail = 0;
  bit m_s1 = 0;
  bit m_ls = 0;

  logic [12:0] dut_vec;
  assign dut_vec = {state_o, pll_rst, sys_rst_n, pll_fail, loss_cnt};

  function automatic logic [12:0] exp_vec();
    return {m_state[1:0], (m_state == 0), (m_state == 3), m_fail, m_loss[7:0]};
  endfunction

  task automatic attempt_failed();
    if (m_retries < MR) m_retries++;
    if (m_retries == MR) m_fail = 1;
  endtask

  task automatic model_step();
    bit ls;
    if (!rst_n) begin
      m_state = 0; m_in = 0; m_retries = 0; m_loss = 0; m_fail = 0; m_s1 = 0; m_ls = 0;
    end else begin
      ls = m_ls;
      m_ls = m_s1;
      m_s1 = locked;
      m_in++;
      case (m_state)
        0: if (m_in == RST) begin m_state = 1; m_in = 0; end
        1: begin
          if (ls) begin m_state = 2; m_in = 0; end
          else if (m_in == TO) begin m_state = 0; m_in = 0; attempt_failed(); end
        end
        2: begin
          if (!ls) begin m_state = 0; m_in = 0; attempt_failed(); end
          else if (m_in == ST) begin m_state = 3; m_in = 0; m_retries = 0; end
        end
        default: if (!ls) begin m_state = 0; m_in = 0; if (m_loss < 255) m_loss++; end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_state(input int s, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (m_state == s) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    locked = 1'($urandom_range(0, 1));
    repeat (3) tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    checks++; if (pll_fail !== 1'b0) begin errors++; $display("FAIL reset_pll_fail: got %b want 0", pll_fail); end
    checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt); end
    rst_n = 1;
  endtask

  task automatic test_nominal();
    int prst, nstab, run_edge, wait_edge;
    rst_n = 0; locked = 0; tick(); rst_n = 1;
    prst = int'(pll_rst); nstab = 0; run_edge = -1; wait_edge = -1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 11) locked = 1;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL nominal_cyc%0d: got %h want %h", e, dut_vec, exp_vec()); end
      prst += int'(pll_rst);
      if (state_o == 2'd2) nstab++;
      if (state_o == 2'd1 && wait_edge < 0) wait_edge = e;
      if (state_o == 2'd3 && run_edge < 0) run_edge = e;
    end
    checks++; if (prst != RST) begin errors++; $display("FAIL nominal_pll_rst_len: got %0d want %0d", prst, RST); end
    checks++; if (wait_edge != RST) begin errors++; $display("FAIL nominal_wait_edge: got %0d want %0d", wait_edge, RST); end
    checks++; if (nstab != ST) begin errors++; $display("FAIL nominal_stable_len: got %0d want %0d", nstab, ST); end
    checks++; if (run_edge != 10 + 2 + 1 + ST) begin errors++; $display("FAIL nominal_run_edge: got %0d want %0d", run_edge, 10 + 2 + 1 + ST); end
    checks++; if (sys_rst_n !== 1'b1 || state_o !== 2'd3) begin errors++; $display("FAIL nominal_run: got sys=%b st=%0d want 1/3", sys_rst_n, state_o); end
  endtask

  task automatic test_timeout_fail();
    int fail_edge, sys_hi;
    rst_n = 0; locked = 0; tick(); rst_n = 1;
    fail_edge = -1; sys_hi = 0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL timeout_cyc%0d: got %h want %h", e, dut_vec, exp_vec()); end
      if (pll_fail === 1'b1 && fail_edge < 0) fail_edge = e;
      sys_hi += int'(sys_rst_n);
    end
    checks++; if (fail_edge != 3 * (RST + TO)) begin errors++; $display("FAIL timeout_fail_edge: got %0d want %0d", fail_edge, 3 * (RST + TO)); end
    checks++; if (sys_hi != 0) begin errors++; $display("FAIL timeout_sys_rst_n: got %0d high cycles want 0", sys_hi); end
    checks++; if (state_o !== 2'd1 || pll_fail !== 1'b1) begin errors++; $display("FAIL timeout_retry_continues: got st=%0d fail=%b want 1/1", state_o, pll_fail); end
  endtask

  task automatic test_glitch();
    bit ok;
    rst_n = 0; locked = 1; tick(); rst_n = 1;
    wait_state(2, 50, ok);
    checks++; if (!ok || state_o !== 2'd2) begin errors++; $display("FAIL glitch_reach_stable: got st=%0d want 2", state_o); end
    repeat (4) tick();
    locked = 0; tick(); locked = 1;
    repeat (2) tick();
    checks++; if (state_o !== 2'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL glitch_to_reset: got st=%0d rst=%b want 0/1", state_o, pll_rst); end
    wait_state(3, 100, ok);
    checks++; if (!ok || state_o !== 2'd3 || pll_fail !== 1'b0) begin errors++; $display("FAIL glitch_relock: got st=%0d fail=%b want 3/0", state_o, pll_fail); end
    locked = 0;
    for (int e = 1; e <= 81; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch_cyc%0d: got %h want %h", e, dut_vec, exp_vec()); end
      if (e == 61) begin
        checks++; if (pll_fail !== 1'b0) begin errors++; $display("FAIL glitch_retry_cleared: got fail=%b want 0", pll_fail); end
      end
    end
    checks++; if (pll_fail !== 1'b1) begin errors++; $display("FAIL glitch_third_fail: got fail=%b want 1", pll_fail); end
  endtask

  task automatic test_lock_loss();
    bit ok, ok1, all_ok;
    logic c1, c2;
    rst_n = 0; locked = 1; tick(); rst_n = 1;
    wait_state(3, 100, ok);
    checks++; if (!ok || sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_reach_run: got sys=%b want 1", sys_rst_n); end
    locked = 0;
    tick(); c1 = sys_rst_n;
    tick(); c2 = sys_rst_n;
    tick();
    checks++; if (c1 !== 1'b1 || c2 !== 1'b1) begin errors++; $display("FAIL loss_early_drop: got %b%b want 11", c1, c2); end
    checks++; if (sys_rst_n !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL loss_edge3: got sys=%b rst=%b want 0/1", sys_rst_n, pll_rst); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt1: got %0d want 1", loss_cnt); end
    all_ok = 1;
    for (int i = 2; i <= 256; i++) begin
      locked = 1; wait_state(3, 100, ok1); all_ok &= ok1;
      locked = 0; wait_state(0, 10, ok1); all_ok &= ok1;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL loss_loop_progress: got stalled want progress"); end
    checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL loss_saturate: got %0d want 255", loss_cnt); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL loss_model: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_boundary();
    rst_n = 0; locked = 0; tick(); rst_n = 1;
    repeat (21) tick();
    locked = 1;
    repeat (3) tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL boundary_lock_wins: got st=%0d want 2", state_o); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL boundary_model_a: got %h want %h", dut_vec, exp_vec()); end
    rst_n = 0; locked = 0; tick(); rst_n = 1;
    repeat (22) tick();
    locked = 1;
    repeat (2) tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL boundary_late_lock: got st=%0d want 0", state_o); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL boundary_model_b: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_midop_reset();
    bit ok, all_ok;
    int n;
    rst_n = 0; locked = 0; tick(); rst_n = 1;
    n = 0;
    while (!m_fail && n < 200) begin tick(); n++; end
    checks++; if (pll_fail !== 1'b1) begin errors++; $display("FAIL midop_fail_set: got %b want 1", pll_fail); end
    locked = 1; wait_state(3, 100, all_ok);
    for (int i = 0; i < 5; i++) begin
      locked = 0; wait_state(0, 10, ok); all_ok &= ok;
      locked = 1; wait_state(3, 100, ok); all_ok &= ok;
    end
    checks++; if (!all_ok || state_o !== 2'd3 || loss_cnt !== 8'd5 || pll_fail !== 1'b1) begin
      errors++; $display("FAIL midop_setup: got st=%0d loss=%0d fail=%b want 3/5/1", state_o, loss_cnt, pll_fail);
    end
    rst_n = 0; tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL midop_state: got %0d want 0", state_o); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL midop_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL midop_sys_rst_n: got %b want 0", sys_rst_n); end
    checks++; if (pll_fail !== 1'b0) begin errors++; $display("FAIL midop_pll_fail: got %b want 0", pll_fail); end
    checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL midop_loss_cnt: got %0d want 0", loss_cnt); end
    rst_n = 1;
  endtask

  task automatic test_random();
    int left;
    rst_n = 0; tick(); rst_n = 1;
    left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (left == 0) begin
        locked = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 30);
      end
      left--;
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_cyc%0d: got %h want %h", c, dut_vec, exp_vec()); end
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    locked = 0;
    test_reset();
    test_nominal();
    test_timeout_fail();
    test_glitch();
    test_lock_loss();
    test_boundary();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time limit, want completion");
    $fatal(1);
  end

endmodule
